// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: write-data sources,
// forwarding selects and the memory-handshake FSM states.
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] WD_SEL_ALU  = 2'b00;
    localparam logic [1:0] WD_SEL_DMEM = 2'b01;
    localparam logic [1:0] WD_SEL_PC4  = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_IM_WAIT    = 2'd1,
        ST_IM_DISCARD = 2'd2,
        ST_DM_WAIT    = 2'd3
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rf_ra0, id_rf_ra1;
    logic             id_rf_re0, id_rf_re1;
    logic [4:0]       ex_rf_wa, mem_rf_wa, wb_rf_wa;
    logic             ex_rf_we, mem_rf_we, wb_rf_we;
    logic [1:0]       ex_rf_wd_sel, mem_rf_wd_sel;
    logic             ex_jal, ex_jalr, ex_br;
    logic             im_req, im_rvalid;
    logic             mem_dm_re, mem_dm_we;
    logic             dm_rvalid, dm_wvalid;
    logic             stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
    logic             flush_ifid, flush_idex, flush_exmem, flush_memwb;
    logic [1:0]       fwd0_sel, fwd1_sel;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rf_ra0, id_rf_ra1, id_rf_re0, id_rf_re1,
               ex_rf_wa, mem_rf_wa, wb_rf_wa, ex_rf_we, mem_rf_we, wb_rf_we,
               ex_rf_wd_sel, mem_rf_wd_sel, ex_jal, ex_jalr, ex_br,
               im_req, im_rvalid, mem_dm_re, mem_dm_we, dm_rvalid, dm_wvalid,
        input  stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
               flush_ifid, flush_idex, flush_exmem, flush_memwb,
               fwd0_sel, fwd1_sel, mem_err, stall_cycles
    );

    modport slave (
        input  id_rf_ra0, id_rf_ra1, id_rf_re0, id_rf_re1,
               ex_rf_wa, mem_rf_wa, wb_rf_wa, ex_rf_we, mem_rf_we, wb_rf_we,
               ex_rf_wd_sel, mem_rf_wd_sel, ex_jal, ex_jalr, ex_br,
               im_req, im_rvalid, mem_dm_re, mem_dm_we, dm_rvalid, dm_wvalid,
        output stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
               flush_ifid, flush_idex, flush_exmem, flush_memwb,
               fwd0_sel, fwd1_sel, mem_err, stall_cycles
    );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Zero-latency forwarding select for one ID source operand.
module hazard_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter logic [1:0] WD_SEL_MEM = WD_SEL_DMEM
) (
    input  logic [4:0] ra,
    input  logic       mem_rf_we,
    input  logic [4:0] mem_rf_wa,
    input  logic [1:0] mem_rf_wd_sel,
    input  logic       wb_rf_we,
    input  logic [4:0] wb_rf_wa,
    output logic [1:0] fwd_sel
);

    // A load in MEM has no data yet, so it falls through to the WB check.
    always_comb begin
        fwd_sel = FWD_RF;
        if (ra != 5'd0) begin
            if (mem_rf_we && (mem_rf_wa == ra) && (mem_rf_wd_sel != WD_SEL_MEM)) begin
                fwd_sel = FWD_MEM;
            end else if (wb_rf_we && (wb_rf_wa == ra)) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush generation, ID forwarding selects, memory-handshake tracking,
// timeout flag and stall-cycle counter for a 5-stage pipeline.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter logic [1:0] WD_SEL_MEM  = WD_SEL_DMEM,
    parameter int         MEM_TIMEOUT = 255,
    parameter int         CNT_W       = 32
) (
    input logic                   clk,
    input logic                   rstn,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int               TMO_W   = $clog2(MEM_TIMEOUT + 2);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

    hz_state_e        state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_err_q;

    logic             dm_busy, im_busy, load_use, redirect;
    logic             use0, use1;
    logic [1:0]       fwd0_raw, fwd1_raw;

    assign dm_busy  = (hz.mem_dm_re & ~hz.dm_rvalid) | (hz.mem_dm_we & ~hz.dm_wvalid);
    assign im_busy  = hz.im_req & ~hz.im_rvalid;
    assign redirect = hz.ex_jal | hz.ex_jalr | hz.ex_br;
    assign use0     = hz.id_rf_re0 & (hz.id_rf_ra0 == hz.ex_rf_wa);
    assign use1     = hz.id_rf_re1 & (hz.id_rf_ra1 == hz.ex_rf_wa);
    assign load_use = hz.ex_rf_we & (hz.ex_rf_wd_sel == WD_SEL_MEM) &
                      (hz.ex_rf_wa != 5'd0) & (use0 | use1);

    hazard_fwd_unit #(.WD_SEL_MEM(WD_SEL_MEM)) u_fwd0 (
        .ra            (hz.id_rf_ra0),
        .mem_rf_we     (hz.mem_rf_we),
        .mem_rf_wa     (hz.mem_rf_wa),
        .mem_rf_wd_sel (hz.mem_rf_wd_sel),
        .wb_rf_we      (hz.wb_rf_we),
        .wb_rf_wa      (hz.wb_rf_wa),
        .fwd_sel       (fwd0_raw)
    );

    hazard_fwd_unit #(.WD_SEL_MEM(WD_SEL_MEM)) u_fwd1 (
        .ra            (hz.id_rf_ra1),
        .mem_rf_we     (hz.mem_rf_we),
        .mem_rf_wa     (hz.mem_rf_wa),
        .mem_rf_wd_sel (hz.mem_rf_wd_sel),
        .wb_rf_we      (hz.wb_rf_we),
        .wb_rf_wa      (hz.wb_rf_wa),
        .fwd_sel       (fwd1_raw)
    );

    // Reset forces bubbles everywhere; a redirect outranks load-use since ID is wrong-path.
    always_comb begin
        hz.stall_pc    = 1'b0;
        hz.stall_ifid  = 1'b0;
        hz.stall_idex  = 1'b0;
        hz.stall_exmem = 1'b0;
        hz.stall_memwb = 1'b0;
        hz.flush_ifid  = 1'b0;
        hz.flush_idex  = 1'b0;
        hz.flush_exmem = 1'b0;
        hz.flush_memwb = 1'b0;
        hz.fwd0_sel    = rstn ? fwd0_raw : FWD_RF;
        hz.fwd1_sel    = rstn ? fwd1_raw : FWD_RF;
        if (!rstn) begin
            hz.flush_ifid  = 1'b1;
            hz.flush_idex  = 1'b1;
            hz.flush_exmem = 1'b1;
            hz.flush_memwb = 1'b1;
        end else if (dm_busy) begin
            hz.stall_pc    = 1'b1;
            hz.stall_ifid  = 1'b1;
            hz.stall_idex  = 1'b1;
            hz.stall_exmem = 1'b1;
            hz.flush_memwb = 1'b1;
        end else if (redirect) begin
            hz.flush_ifid  = 1'b1;
            hz.flush_idex  = 1'b1;
        end else if (load_use) begin
            hz.stall_pc    = 1'b1;
            hz.stall_ifid  = 1'b1;
            hz.flush_idex  = 1'b1;
        end else if ((state == ST_IM_DISCARD) || im_busy) begin
            hz.stall_pc    = 1'b1;
            hz.flush_ifid  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_RUN;
            tmo_cnt   <= '0;
            mem_err_q <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (dm_busy) begin
                state <= ST_DM_WAIT;
            end else begin
                case (state)
                    ST_RUN:        if (im_busy) state <= redirect ? ST_IM_DISCARD : ST_IM_WAIT;
                    ST_IM_WAIT:    if (hz.im_rvalid) state <= ST_RUN;
                                   else if (redirect) state <= ST_IM_DISCARD;
                    ST_IM_DISCARD: if (hz.im_rvalid) state <= ST_RUN;
                    default:       state <= ST_RUN;
                endcase
            end

            if (state == ST_RUN) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if ((MEM_TIMEOUT != 0) && (state != ST_RUN) && ((tmo_cnt + TMO_W'(1)) == TMO_LIM)) begin
                mem_err_q <= 1'b1;
            end

            if (hz.stall_pc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.mem_err      = mem_err_q;
    assign hz.stall_cycles = stall_cnt;

endmodule
